ln05lpe_sram_fifo_ctrl: RTL
===========================

# ln05lpe_sram_fifo_ctrl

Synchronous FIFO controller placed directly upstream of the 256x1026 two-port SRAM wrapper (`ln05lpe_a00_mc_rd2r_hsr_lvt_256x1026m2b1c0_wrapper_WRP1_I0O0`). It drives that macro's write port (WEN/WA/DI) and read port (REN/RA), and consumes its DOUT. It presents valid/ready push and pop interfaces to the datapath. A 2-entry output prefetch buffer hides the macro's 1-cycle read latency so that sustained throughput is one word per cycle.

## Interface
- `DW`, 1026: data width; must equal the wrapper `dataWidth`.
- `AW`, 8: SRAM address width.
- `DEPTH`, 256: SRAM entries; equals 2^AW.
- `CK` in 1: clock; all state is updated on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `in_valid` in 1: push request.
- `in_ready` out 1: push accept; a push occurs when `in_valid & in_ready`.
- `in_data` in DW: push data.
- `out_valid` out 1: head word available.
- `out_ready` in 1: pop accept; a pop occurs when `out_valid & out_ready`.
- `out_data` out DW: head word.
- `count` out AW+1: total occupancy, counting SRAM entries, reads in flight and buffered words. Range 0..DEPTH+2.
- `mem_wen` out 1: to wrapper WEN, active-low.
- `mem_wa` out AW: to WA.
- `mem_di` out DW: to DI.
- `mem_ren` out 1: to REN, active-low.
- `mem_ra` out AW: to RA.
- `mem_dout` in DW: from DOUT; valid in the cycle after the cycle in which `mem_ren=0`.

## Operation
- **State:**
  - `wptr`, `rptr`: AW-bit pointers, wrapping naturally from 255 to 0.
  - `mem_cnt`: AW+1 bits, 0..DEPTH; counts written, unread SRAM entries.
  - `rd_pend`: 1 bit; a read was issued last cycle.
  - Output buffer: 2 entries, `buf_cnt` 0..2, FIFO order.
- **Write:**
  - A push drives `mem_wen=0`, `mem_wa=wptr`, `mem_di=in_data` combinationally.
  - `wptr` increments; `mem_cnt` increments at the next edge.
- **`in_ready`:** registered; equals `mem_cnt != DEPTH`, computed from next-state values.
- **Read issue:** when `mem_cnt != 0 && (buf_cnt + rd_pend - pop) < 2`:
  - Drive `mem_ren=0`, `mem_ra=rptr`.
  - `rptr` increments; `mem_cnt` decrements; `rd_pend` is set to 1.
- **Capture:** when `rd_pend=1`, `mem_dout` is written into the output buffer tail.
- **`out_valid`:** equals `buf_cnt != 0`. `out_data` is the buffer head, stable while `out_valid & !out_ready`.
- **Simultaneous write and read issue:** `mem_cnt` is unchanged.
- **Simultaneous capture and pop:** `buf_cnt` is unchanged and order is preserved.
- **Collision:** a read never targets the same address as a same-cycle write. A read requires a committed entry (`mem_cnt>0`), and a write requires `mem_cnt<DEPTH`. The pointers are therefore equal only at 0 or DEPTH, where one of the two operations is blocked.
- **Idle ports:** `mem_wen`/`mem_ren` are held at 1; `mem_wa`/`mem_ra`/`mem_di` hold their last values (don't-care).
- **Full/empty:** a push with `in_ready=0` is ignored. `out_valid=0` when `count=0`.

## Timing
- **Reset (RST high at an edge):**
  - Pointers, `mem_cnt`, `buf_cnt`, `rd_pend` and `count` clear to 0.
  - `out_valid=0`, `out_data=0`, `in_ready=0` while RST is asserted, then 1 in the first cycle after release.
  - `mem_wen=mem_ren=1` throughout reset.
- **Reset mid-operation:** all contents are discarded. A read in flight is dropped; its `mem_dout` is not captured after reset.
- **First-word latency:** push in cycle t gives a read issue at t+1, capture at the t+2 edge, and `out_valid` at t+3.
- **Throughput:** sustained 1 push and 1 pop per cycle once primed.
- **Backpressure:** with `out_ready=0`, at most 2 words are buffered and no further reads are issued. Capacity is DEPTH+2 words; `in_ready` falls when `mem_cnt` reaches 256.
- **`count`:** registered; reflects pushes and pops of the previous cycle.

## Structure
- Shared package `ln05lpe_fifo_pkg`:
  - `localparam` defaults `DW`/`AW`/`DEPTH`.
  - Typedefs `addr_t` (AW bits), `cnt_t` (AW+1 bits), `word_t` (DW bits).
  - Constant `MEM_EN_ACT = 1'b0`.
- One sub-module `ln05lpe_fifo_outbuf`: the 2-entry skid/prefetch buffer, with capture input, pop handshake and `buf_cnt` output.
- The SRAM wrapper is instantiated by the parent, not inside this block.

## Test plan
- **Reset:** hold RST 3 cycles with `in_valid=1` → `in_ready=0`, `mem_wen=1`, `out_valid=0`, `count=0`. Release → `in_ready=1` next cycle.
- **Single word:** push `0x155…5` in cycle 10 → `mem_wen=0`, `mem_wa=0` in cycle 10; `mem_ren=0`, `mem_ra=0` in cycle 11; `out_valid=1` with matching data in cycle 13.
- **Fill:** `out_ready=0`, push 260 words → exactly 258 accepted; `in_ready=0` after push 258; `count=258`. Drain → data 1..258 in order, `count` back to 0.
- **Streaming:** `in_valid=out_ready=1` for 1000 cycles with incrementing data → one pop per cycle after the 3-cycle prime, no gaps. Both pointers wrap past 255 → 0 with correct data.
- **Random backpressure:** 50% random `out_ready` and `in_valid` over 10k cycles → scoreboard match. Check `mem_ra != mem_wa` whenever both enables are 0 in the same cycle.
- **Mid-operation reset:** assert RST for 1 cycle while `count=100` and a read is in flight → `count=0`, `out_valid=0` the next cycle. A subsequent push returns the new data, not stale data.

Source files
------------

// File: rtl/ln05lpe_sram_fifo_ctrl_pkg.sv
// Shared widths, types and constants for the SRAM FIFO controller.
package ln05lpe_fifo_pkg;

    localparam int DW    = 1026;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   cnt_t;
    typedef logic [DW-1:0] word_t;

    // The macro enables are active-low.
    localparam logic MEM_EN_ACT  = 1'b0;
    localparam logic MEM_EN_IDLE = 1'b1;

    localparam cnt_t CNT_ZERO = {(AW+1){1'b0}};
    localparam cnt_t CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

    // Map an active-high request onto the macro's active-low enable.
    function automatic logic mem_en(input logic req);
        return req ? MEM_EN_ACT : MEM_EN_IDLE;
    endfunction

endpackage

// File: rtl/ln05lpe_sram_fifo_ctrl_if.sv
// Push/pop valid-ready bundle between the datapath and the FIFO controller.
interface ln05lpe_sram_fifo_ctrl_if;
    import ln05lpe_fifo_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t in_data;
    logic  out_valid;
    logic  out_ready;
    word_t out_data;

    // FIFO side: accepts pushes, presents the head word.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    // Datapath side: produces pushes, consumes pops.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/ln05lpe_sram_fifo_ctrl_outbuf.sv
// Two-entry prefetch/skid buffer that hides the SRAM read latency.
// Entry 0 is always the head; entry 1 is only valid when buf_cnt is 2.
module ln05lpe_fifo_outbuf
    import ln05lpe_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cap_valid,
    input  word_t      cap_data,
    input  logic       out_ready,
    output logic       pop,
    output logic       out_valid,
    output word_t      out_data,
    output logic [1:0] buf_cnt
);

    word_t      ent0_q, ent0_d;
    word_t      ent1_q, ent1_d;
    logic [1:0] buf_cnt_q, buf_cnt_d;
    logic       out_valid_q, out_valid_d;

    // Pop handshake is qualified by the registered head-valid flag.
    always_comb begin
        pop = out_valid_q & out_ready;
    end

    // Next buffer contents: capture appends at the tail, pop shifts entry 1 to the head.
    always_comb begin
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        buf_cnt_d = buf_cnt_q;
        case ({cap_valid, pop})
            2'b10: begin
                if (buf_cnt_q == 2'd0) begin
                    ent0_d    = cap_data;
                    buf_cnt_d = 2'd1;
                end else if (buf_cnt_q == 2'd1) begin
                    ent1_d    = cap_data;
                    buf_cnt_d = 2'd2;
                end else begin
                    buf_cnt_d = buf_cnt_q;
                end
            end
            2'b01: begin
                ent0_d    = ent1_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the captured word lands behind any remaining one.
                if (buf_cnt_q == 2'd1) begin
                    ent0_d = cap_data;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = cap_data;
                end
            end
            default: begin
                buf_cnt_d = buf_cnt_q;
            end
        endcase
        out_valid_d = (buf_cnt_d != 2'd0);
    end

    // Buffer state registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q      <= {DW{1'b0}};
            ent1_q      <= {DW{1'b0}};
            buf_cnt_q   <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            ent0_q      <= ent0_d;
            ent1_q      <= ent1_d;
            buf_cnt_q   <= buf_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = ent0_q;
    assign buf_cnt   = buf_cnt_q;

endmodule

// File: rtl/ln05lpe_sram_fifo_ctrl.sv
// FIFO controller in front of the 256x1026 two-port SRAM wrapper. Writes go
// straight to the macro; reads are prefetched into a 2-entry output buffer so
// the 1-cycle macro read latency does not limit throughput.
module ln05lpe_sram_fifo_ctrl
    import ln05lpe_fifo_pkg::*;
(
    input  logic                         CK,
    input  logic                         RST,
    ln05lpe_sram_fifo_ctrl_if.slave      bus,
    output cnt_t                         count,
    output logic                         mem_wen,
    output addr_t                        mem_wa,
    output word_t                        mem_di,
    output logic                         mem_ren,
    output addr_t                        mem_ra,
    input  word_t                        mem_dout
);

    addr_t      wptr_q, wptr_d;
    addr_t      rptr_q, rptr_d;
    cnt_t       mem_cnt_q, mem_cnt_d;
    cnt_t       count_q, count_d;
    logic       rd_pend_q, rd_pend_d;
    logic       in_ready_q, in_ready_d;
    logic       push_s;
    logic       pop_s;
    logic       rd_issue_s;
    logic [1:0] buf_cnt_s;
    logic [2:0] buf_need_s;

    // Qualify the push and decide whether a prefetch read fits in the buffer.
    // The pop term lets a read issue in the same cycle a buffered word leaves.
    always_comb begin
        push_s     = bus.in_valid & in_ready_q & ~RST;
        buf_need_s = {1'b0, buf_cnt_s} + {2'b00, rd_pend_q} - {2'b00, pop_s};
        rd_issue_s = (mem_cnt_q != CNT_ZERO) && (buf_need_s < 3'd2) && !RST;
    end

    // Pointer, occupancy and ready next-state.
    always_comb begin
        wptr_d    = wptr_q + addr_t'(push_s);
        rptr_d    = rptr_q + addr_t'(rd_issue_s);
        rd_pend_d = rd_issue_s;
        case ({push_s, rd_issue_s})
            2'b10:   mem_cnt_d = mem_cnt_q + CNT_ONE;
            2'b01:   mem_cnt_d = mem_cnt_q - CNT_ONE;
            default: mem_cnt_d = mem_cnt_q;
        endcase
        count_d    = count_q + cnt_t'(push_s) - cnt_t'(pop_s);
        in_ready_d = (mem_cnt_d != CNT_FULL);
    end

    // Control state registers; reset also drops any read in flight.
    always_ff @(posedge CK) begin
        if (RST) begin
            wptr_q     <= {AW{1'b0}};
            rptr_q     <= {AW{1'b0}};
            mem_cnt_q  <= CNT_ZERO;
            count_q    <= CNT_ZERO;
            rd_pend_q  <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mem_cnt_q  <= mem_cnt_d;
            count_q    <= count_d;
            rd_pend_q  <= rd_pend_d;
            in_ready_q <= in_ready_d;
        end
    end

    ln05lpe_fifo_outbuf u_outbuf (
        .clk       (CK),
        .rst       (RST),
        .cap_valid (rd_pend_q),
        .cap_data  (mem_dout),
        .out_ready (bus.out_ready),
        .pop       (pop_s),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .buf_cnt   (buf_cnt_s)
    );

    assign bus.in_ready = in_ready_q;
    assign count        = count_q;
    // Address/data buses are don't-care while the matching enable is idle.
    assign mem_wen      = mem_en(push_s);
    assign mem_wa       = wptr_q;
    assign mem_di       = bus.in_data;
    assign mem_ren      = mem_en(rd_issue_s);
    assign mem_ra       = rptr_q;

endmodule
